// File: rtl/rvx_board_control_if.sv
// Button inputs and core-control outputs of the board reset/halt sequencer.
// The slave modport is the sequencer's view; master is the board/bench view.
interface rvx_board_control_if;
  logic reset_button;
  logic halt_button;
  logic core_reset_n;
  logic core_halt;
  logic reset_pressed;
  logic halt_pressed;
  logic running;

  modport master (
    output reset_button, halt_button,
    input  core_reset_n, core_halt, reset_pressed, halt_pressed, running
  );

  modport slave (
    input  reset_button, halt_button,
    output core_reset_n, core_halt, reset_pressed, halt_pressed, running
  );
endinterface

// File: rtl/rvx_board_control.sv
// Board reset/halt sequencer: synchronises and debounces the two push-buttons,
// stretches core reset for a hold time and drives core halt (level or toggle).
module rvx_board_control #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter bit          HALT_TOGGLE       = 1'b0
) (
  input logic                clock,
  input logic                reset,
  rvx_board_control_if.slave bus
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StHold, StRun, StAssert} state_e;

  // Index 0 = reset button, index 1 = halt button.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  sync;
  logic [1:0][DebW-1:0]        deb_cnt_q, deb_cnt_d;
  logic [1:0]                  deb_q, deb_d;
  logic [1:0]                  deb_prev_q;
  logic [1:0]                  pressed_q, pressed_d;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              core_reset_n_q, running_q;
  logic              halt_q, halt_d;

  assign raw = {bus.halt_button, bus.reset_button};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // A mismatch must persist DEBOUNCE_CYCLES edges; any return to deb restarts the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = sync[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    pressed_d = deb_q & ~deb_prev_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: ;
      StAssert: begin
        state_d    = StHold;
        hold_cnt_d = '0;
      end
      default: begin
        state_d    = StHold;
        hold_cnt_d = '0;
      end
    endcase
    // A held reset button overrides any pending HOLD->RUN transition.
    if (deb_q[0]) begin
      state_d    = StAssert;
      hold_cnt_d = '0;
    end
  end

  always_comb begin
    halt_d = deb_q[1];
    if (HALT_TOGGLE) begin
      if (pressed_q[0]) begin
        halt_d = 1'b0;
      end else if (pressed_q[1]) begin
        halt_d = ~halt_q;
      end else begin
        halt_d = halt_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q         <= '0;
      deb_cnt_q      <= '0;
      deb_q          <= '0;
      deb_prev_q     <= '0;
      pressed_q      <= '0;
      state_q        <= StHold;
      hold_cnt_q     <= '0;
      core_reset_n_q <= 1'b0;
      running_q      <= 1'b0;
      halt_q         <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      end
      deb_cnt_q      <= deb_cnt_d;
      deb_q          <= deb_d;
      deb_prev_q     <= deb_q;
      pressed_q      <= pressed_d;
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      core_reset_n_q <= (state_d == StRun);
      running_q      <= (state_d == StRun);
      halt_q         <= halt_d;
    end
  end

  assign bus.core_reset_n  = core_reset_n_q;
  assign bus.running       = running_q;
  assign bus.core_halt     = halt_q;
  assign bus.reset_pressed = pressed_q[0];
  assign bus.halt_pressed  = pressed_q[1];

endmodule

// File: tb/tb_rvx_board_control.sv
// Bench for rvx_board_control: level-mode and toggle-mode instances share stimulus
// and are compared every cycle against a behavioural model of the sequencing rules.
module tb_rvx_board_control;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 8;
  localparam int unsigned Sync = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  rvx_board_control_if if_lvl ();
  rvx_board_control_if if_tog ();

  rvx_board_control #(
    .DEBOUNCE_CYCLES(Deb), .RESET_HOLD_CYCLES(Hold), .SYNC_STAGES(Sync), .HALT_TOGGLE(1'b0)
  ) u_lvl (
    .clock(clock), .reset(reset), .bus(if_lvl)
  );

  rvx_board_control #(
    .DEBOUNCE_CYCLES(Deb), .RESET_HOLD_CYCLES(Hold), .SYNC_STAGES(Sync), .HALT_TOGGLE(1'b1)
  ) u_tog (
    .clock(clock), .reset(reset), .bus(if_tog)
  );

  // Reference model state (index 0 = reset button, 1 = halt button).
  bit m_hist_r[$];
  bit m_hist_h[$];
  int m_run[2];
  bit m_deb[2], m_prev[2], m_pulse[2];
  bit m_halt_lvl, m_halt_tog;
  bit m_running, m_in_assert;
  int m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit rb, input bit hb);
    bit s[2];
    bit deb_o[2];
    bit pulse_o[2];
    if (rst) begin
      m_hist_r = {};
      m_hist_h = {};
      for (int i = 0; i < Sync; i++) begin
        m_hist_r.push_back(1'b0);
        m_hist_h.push_back(1'b0);
      end
      for (int b = 0; b < 2; b++) begin
        m_run[b] = 0; m_deb[b] = 0; m_prev[b] = 0; m_pulse[b] = 0;
      end
      m_halt_lvl = 0; m_halt_tog = 0; m_running = 0; m_in_assert = 0; m_hold = 0;
    end else begin
      deb_o   = m_deb;
      pulse_o = m_pulse;
      s[0] = m_hist_r[Sync-1];
      s[1] = m_hist_h[Sync-1];
      m_hist_r.push_front(rb);
      void'(m_hist_r.pop_back());
      m_hist_h.push_front(hb);
      void'(m_hist_h.pop_back());
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = deb_o[b] && !m_prev[b];
        m_prev[b]  = deb_o[b];
        if (s[b] != deb_o[b]) begin
          m_run[b]++;
          if (m_run[b] == Deb) begin
            m_deb[b] = s[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_halt_lvl = deb_o[1];
      if (pulse_o[0]) m_halt_tog = 0;
      else if (pulse_o[1]) m_halt_tog = !m_halt_tog;
      if (deb_o[0]) begin
        m_in_assert = 1; m_running = 0; m_hold = 0;
      end else if (m_in_assert) begin
        m_in_assert = 0; m_hold = 0;
      end else if (!m_running) begin
        if (m_hold == Hold - 1) begin
          m_running = 1; m_hold = 0;
        end else begin
          m_hold++;
        end
      end
    end
  endtask

  task automatic tick(input bit rst, input bit rb, input bit hb);
    @(negedge clock);
    reset = rst;
    if_lvl.reset_button = rb; if_lvl.halt_button = hb;
    if_tog.reset_button = rb; if_tog.halt_button = hb;
    @(posedge clock);
    model_edge(rst, rb, hb);
    #1;
    check("lvl_core_reset_n", if_lvl.core_reset_n, m_running);
    check("lvl_running", if_lvl.running, m_running);
    check("lvl_core_halt", if_lvl.core_halt, m_halt_lvl);
    check("lvl_reset_pressed", if_lvl.reset_pressed, m_pulse[0]);
    check("lvl_halt_pressed", if_lvl.halt_pressed, m_pulse[1]);
    check("tog_core_reset_n", if_tog.core_reset_n, m_running);
    check("tog_core_halt", if_tog.core_halt, m_halt_tog);
    check("tog_reset_pressed", if_tog.reset_pressed, m_pulse[0]);
  endtask

  initial begin
    int pulses;
    bit rb, hb;
    if_lvl.reset_button = 0; if_lvl.halt_button = 0;
    if_tog.reset_button = 0; if_tog.halt_button = 0;

    // Power-up: core_reset_n low for exactly Hold edges after deassert.
    for (int k = 0; k < 3; k++) tick(1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(0, 0, 0);
      if (k == Hold - 1) check("pwr_still_held", if_lvl.core_reset_n, 0);
      if (k == Hold) check("pwr_released", if_lvl.core_reset_n, 1);
      if (k == Hold) check("pwr_running", if_lvl.running, 1);
    end

    // Glitchy reset button never debounces.
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      rb = (k < 3) || (k >= 4 && k < 7);
      tick(0, rb, 0);
      pulses += int'(if_lvl.reset_pressed);
      check("glitch_rst_n", if_lvl.core_reset_n, 1);
    end
    check("glitch_no_pulse", pulses, 0);

    // Halt level: rises 6 edges after first sampling edge, falls 6 after release.
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, k < 10);
      pulses += int'(if_lvl.halt_pressed);
      if (k == 5)  check("halt_lvl_pre_rise", if_lvl.core_halt, 0);
      if (k == 6)  check("halt_lvl_rise", if_lvl.core_halt, 1);
      if (k == 15) check("halt_lvl_pre_fall", if_lvl.core_halt, 1);
      if (k == 16) check("halt_lvl_fall", if_lvl.core_halt, 0);
    end
    check("halt_lvl_one_pulse", pulses, 1);

    // Priority: debounced reset arrives when the hold counter reaches its last value.
    tick(1, 0, 0); tick(1, 0, 0);
    tick(0, 0, 0);
    for (int k = 2; k <= 10; k++) begin
      tick(0, 1, 0);
      if (k == Hold) check("prio_no_run", if_lvl.core_reset_n, 0);
      if (k == Hold) check("prio_not_running", if_lvl.running, 0);
    end
    for (int k = 0; k < 30; k++) tick(0, 0, 0);

    // Global reset mid-hold restarts the full hold count.
    tick(1, 0, 0); tick(1, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0);
    tick(1, 0, 0);
    for (int k = 1; k <= Hold; k++) begin
      tick(0, 0, 0);
      if (k == Hold - 1) check("midhold_still_held", if_lvl.core_reset_n, 0);
      if (k == Hold) check("midhold_released", if_lvl.core_reset_n, 1);
    end

    // Toggle mode: three presses, then a reset press clears the latch.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 14; k++) tick(0, 0, k < 6);
      check("tog_after_press", if_tog.core_halt, (p % 2) == 0);
    end
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 0);
      if (k == 6) check("tog_rst_pulse", if_tog.reset_pressed, 1);
      if (k == 7) check("tog_cleared", if_tog.core_halt, 0);
    end
    for (int k = 0; k < 30; k++) tick(0, 0, 0);

    // Random segments of button levels with occasional global resets.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) tick(1, $urandom_range(0, 1), $urandom_range(0, 1));
      end
      rb  = ($urandom_range(0, 3) == 0);
      hb  = $urandom_range(0, 1);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) tick(0, rb, hb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rvx_board_control.md
Name: rvx_board_control

Overview:
Board-level reset/halt sequencer between raw push-buttons and the rvx core's reset_n/halt inputs. It synchronises and debounces both buttons and holds the core in reset for a programmable time after global reset or a button release. It drives core halt either as a level or as a press-to-toggle latch. One instance per board top, in the core clock domain.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (>=1; 10 ms at 50 MHz)
RESET_HOLD_CYCLES, 16, cycles core_reset_n stays low after reset source is released (>=1)
SYNC_STAGES, 2, synchroniser flops per button input (>=2)
HALT_TOGGLE, 0, 0 = core_halt follows debounced halt button level; 1 = each halt press toggles core_halt

Ports:
clock  input  1  core clock; all state on rising edge
reset  input  1  global reset, synchronous, active-high
reset_button  input  1  raw asynchronous reset push-button, active-high
halt_button  input  1  raw asynchronous halt push-button, active-high
core_reset_n  output  1  to rvx reset_n, active-low, registered
core_halt  output  1  to rvx halt, registered
reset_pressed  output  1  one-cycle pulse on debounced reset_button rising edge
halt_pressed  output  1  one-cycle pulse on debounced halt_button rising edge
running  output  1  high while FSM in RUN

Behaviour:
- One clock; reset is synchronous and active-high. While reset=1 at an edge: synchroniser flops 0, debounced levels 0, debounce counters 0, FSM=HOLD, hold counter 0, core_reset_n=0, core_halt=0, reset_pressed=0, halt_pressed=0, running=0.
- Synchroniser: SYNC_STAGES-flop chain per button; last stage is "sync".
- Debouncer, per button, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == deb: counter <= 0.
  - sync != deb and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync, counter <= 0.
  - Any glitch back to deb value restarts the count; counter never wraps.
  - deb changes exactly DEBOUNCE_CYCLES edges after sync first differs, when stable throughout.
- Press pulses: reset_pressed/halt_pressed high for exactly the one cycle after deb goes 0->1; never on 1->0.
- Reset FSM (states HOLD, RUN, ASSERT):
  - HOLD: core_reset_n=0. Hold counter increments each cycle; when it equals RESET_HOLD_CYCLES-1 -> RUN, counter <= 0.
  - RUN: core_reset_n=1, running=1.
  - ASSERT: core_reset_n=0, hold counter held at 0.
  - Debounced reset button high in any state -> ASSERT, counter <= 0. This has priority over the HOLD->RUN transition in the same cycle.
  - ASSERT with debounced reset button low -> HOLD.
  - core_reset_n and running are registered from next state; they first read RUN values RESET_HOLD_CYCLES edges after reset deasserts.
- Halt:
  - HALT_TOGGLE=0: core_halt <= debounced halt level.
  - HALT_TOGGLE=1: core_halt inverts on each halt_pressed. The latch is cleared to 0 by global reset and by reset_pressed. If both pulses occur in the same cycle, clear wins.
  - In both modes core_halt is independent of the FSM state; it is not forced low during HOLD or ASSERT.
- Global reset asserted mid-debounce or mid-hold discards all progress and restarts in HOLD.

Test Plan:
(All tests: DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, SYNC_STAGES=2.)
1. Power-up: reset=1 for 3 cycles, then 0, buttons low -> core_reset_n=0 for exactly 8 edges after deassert, then 1; running=1 from the same edge; core_halt=0 throughout.
2. Debounce timing: in RUN, raise reset_button and hold -> reset_pressed pulses once, 2+4 edges after first sampling edge, plus 1 cycle. core_reset_n=0 on the edge after deb rises. Release -> deb low after 2+4 edges, then core_reset_n=1 after 8 more edges.
3. Glitch rejection: reset_button high for 3 cycles, low for 1, high for 3, low -> deb never rises, no pulse, core_reset_n stays 1.
4. Halt level mode (HALT_TOGGLE=0): hold halt_button 10 cycles -> core_halt rises 6 edges after first sampling edge, falls 6 edges after release; one halt_pressed pulse.
5. Halt toggle mode (HALT_TOGGLE=1): three separate presses -> core_halt 0->1->0->1. Then a reset-button press -> core_halt=0 on the cycle after reset_pressed.
6. Priority: reset_button deb rises on the cycle hold counter=7 in HOLD -> FSM enters ASSERT, not RUN; core_reset_n stays 0. Global reset asserted mid-HOLD (counter=5) -> counter restarts, 8 full edges required after deassert.
